// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;
   localparam int NIBBLE_W = 4;
   typedef enum logic [1:0] {IDLE, CALC, DONE} nsa_state_e;
endpackage

// File: rtl/nibble_serial_adder_four_bit_adder.sv
// Single 4-bit ripple slice; the only arithmetic element of the serial adder.
module four_bit_adder
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);
   assign {cout, sum} = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(cin);
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice, LSB nibble first, carry held in a register.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_overflow
);
   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int NIB_SH  = $clog2(NIBBLE_W);

   generate
      if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_width_chk
         $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   nsa_state_e          state;
   logic [IDX_W-1:0]    idx;
   logic                carry;
   logic [WIDTH-1:0]    a_q, b_q;
   logic [IDX_W+NIB_SH-1:0] bit_ofs;
   logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
   logic                nib_cout;
   logic                last;

   // bit offset of the current nibble = idx * 4
   assign bit_ofs = {idx, NIB_SH'(0)};
   assign nib_a   = NIBBLE_W'(a_q >> bit_ofs);
   assign nib_b   = NIBBLE_W'(b_q >> bit_ofs);
   assign last    = (idx == IDX_W'(NIBBLES-1));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   four_bit_adder u_add (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         carry        <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         out_sum      <= '0;
         out_cout     <= 1'b0;
         out_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q     <= in_a;
               b_q     <= in_b;
               carry   <= in_cin;
               idx     <= '0;
               out_sum <= '0;
               state   <= CALC;
            end
            CALC: begin
               // out_sum was cleared at acceptance, so OR-ing in each slice is a plain write
               out_sum <= out_sum | (WIDTH'(nib_sum) << bit_ofs);
               carry   <= nib_cout;
               idx     <= idx + IDX_W'(1);
               if (last) begin
                  out_cout     <= nib_cout;
                  out_overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
                  state        <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench: directed cases on a 16-bit instance, then random traffic on 4/16/32-bit instances.
module tb_nibble_serial_adder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   logic go = 1'b0;
   localparam int NTX = 334;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint sg(input logic [63:0] v, input int w);
      return v[w-1] ? (longint'(v) - (longint'(1) <<< w)) : longint'(v);
   endfunction

   // ---------------- directed 16-bit instance ----------------
   logic        d_iv, d_ir, d_ov, d_ordy, d_cin, d_cout, d_ovf;
   logic [15:0] d_a, d_b, d_sum;

   nibble_serial_adder #(.WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir),
      .in_a(d_a), .in_b(d_b), .in_cin(d_cin), .out_valid(d_ov),
      .out_ready(d_ordy), .out_sum(d_sum), .out_cout(d_cout), .out_overflow(d_ovf)
   );

   // Issue one operation at a negedge and leave the DUT sitting in DONE.
   task automatic dir_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec, input logic eo);
      int k;
      chk({tag, "_rdy"}, d_ir, 1);
      d_iv = 1'b1; d_a = a; d_b = b; d_cin = cin;
      @(negedge clk);
      d_iv = 1'b0; d_a = 16'hDEAD; d_b = 16'hBEEF; d_cin = 1'b1;
      k = 0;
      while (!d_ov && k <= 6) begin
         chk({tag, "_busy"}, d_ir, 0);
         @(negedge clk);
         k++;
      end
      chk({tag, "_lat"}, k, 4);
      chk({tag, "_sum"}, d_sum, es);
      chk({tag, "_cout"}, d_cout, ec);
      chk({tag, "_ovf"}, d_ovf, eo);
   endtask

   task automatic dir_rel(input string tag);
      d_ordy = 1'b1;
      @(negedge clk);
      d_ordy = 1'b0;
      chk({tag, "_idle_vld"}, d_ov, 0);
      chk({tag, "_idle_rdy"}, d_ir, 1);
   endtask

   initial begin
      int t;
      rst_n = 1'b0; d_iv = 1'b0; d_ordy = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sum", d_sum, 0);
      chk("rst_cout", d_cout, 0);
      chk("rst_ovf", d_ovf, 0);
      chk("rst_vld", d_ov, 0);
      chk("rst_rdy", d_ir, 1);
      rst_n = 1'b1;
      @(negedge clk);

      dir_op("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0); dir_rel("basic");
      dir_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); dir_rel("ripple");
      dir_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1); dir_rel("posovf");
      dir_op("cinwrap", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0); dir_rel("cinwrap");
      dir_op("both", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1); dir_rel("both");

      // backpressure: result must hold while out_ready stays low
      dir_op("bp", 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_vld", d_ov, 1);
         chk("bp_hold_rdy", d_ir, 0);
         chk("bp_hold_sum", d_sum, 16'hBE01);
      end
      dir_rel("bp");
      dir_op("b2b", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0); dir_rel("b2b");

      // reset during the second CALC cycle discards the operation
      d_iv = 1'b1; d_a = 16'hABCD; d_b = 16'h1111; d_cin = 1'b0;
      @(negedge clk);
      d_iv = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_sum", d_sum, 0);
      chk("mrst_cout", d_cout, 0);
      chk("mrst_ovf", d_ovf, 0);
      chk("mrst_vld", d_ov, 0);
      chk("mrst_rdy", d_ir, 1);
      rst_n = 1'b1;
      dir_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0); dir_rel("after_rst");

      go = 1'b1;
      t = 0;
      while (done_cnt < 3 && t < 60000) begin
         @(negedge clk);
         t++;
      end
      chk("rnd_done", done_cnt, 3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // ---------------- randomized instances ----------------
   for (genvar g = 0; g < 3; g++) begin : g_rnd
      localparam int W  = (g == 0) ? 4 : ((g == 1) ? 16 : 32);
      localparam int NB = W / 4;
      logic         iv, ir, ov, ordy, cin, cout, ovf;
      logic [W-1:0] a, b, sum;

      nibble_serial_adder #(.WIDTH(W)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
         .in_a(a), .in_b(b), .in_cin(cin), .out_valid(ov),
         .out_ready(ordy), .out_sum(sum), .out_cout(cout), .out_overflow(ovf)
      );

      initial begin
         logic [W-1:0] ta, tb;
         logic         tc, ec, eo;
         logic [63:0]  es;
         longint       u, s, lim;
         int           k;
         iv = 1'b0; ordy = 1'b0; a = '0; b = '0; cin = 1'b0;
         wait (go);
         @(negedge clk);
         lim = longint'(1) <<< (W-1);
         for (int n = 0; n < NTX; n++) begin
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk);
               a = W'($urandom());
            end
            ta = W'($urandom()); tb = W'($urandom()); tc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ta = '1;
            if ($urandom_range(0, 7) == 0) tb = {1'b0, {(W-1){1'b1}}};
            u  = longint'(ta) + longint'(tb) + longint'(tc);
            es = 64'(u % (longint'(1) <<< W));
            ec = 1'(u / (longint'(1) <<< W));
            s  = sg(64'(ta), W) + sg(64'(tb), W) + longint'(tc);
            eo = (s >= lim) || (s < -lim);

            chk($sformatf("w%0d_idle_rdy", W), ir, 1);
            iv = 1'b1; a = ta; b = tb; cin = tc;
            @(negedge clk);
            k = 0;
            while (!ov && k <= NB + 2) begin
               chk($sformatf("w%0d_busy", W), ir, 0);
               iv = 1'($urandom_range(0, 1)); a = W'($urandom()); b = W'($urandom());
               cin = 1'($urandom_range(0, 1)); ordy = 1'($urandom_range(0, 1));
               @(negedge clk);
               k++;
            end
            ordy = 1'b0;
            chk($sformatf("w%0d_lat", W), k, NB);
            chk($sformatf("w%0d_sum", W), 64'(sum), es);
            chk($sformatf("w%0d_cout", W), cout, ec);
            chk($sformatf("w%0d_ovf", W), ovf, eo);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk($sformatf("w%0d_hold_vld", W), ov, 1);
            chk($sformatf("w%0d_hold_sum", W), 64'(sum), es);
            ordy = 1'b1; iv = 1'b0;
            @(negedge clk);
            ordy = 1'b0;
            chk($sformatf("w%0d_rel_vld", W), ov, 0);
         end
         done_cnt++;
      end
   end
endmodule
